fp_mac_norm_round: RTL and testbench
====================================

FP_MAC_NORM_ROUND -- requirements
Module: fp_mac_norm_round

Interface
REQ-001 Parameter WIDTH, default 74: width of the adder sum word consumed by this stage.
REQ-002 Parameter EXP_W, default 8: result exponent width.
REQ-003 Parameter MAN_W, default 23: result stored-fraction width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  stage can accept the input beat this cycle.
REQ-008 in_sum  in  WIDTH  adder result magnitude.
REQ-009 in_carry  in  1  adder carry-out; forms a WIDTH+1 magnitude V = {in_carry, in_sum}.
REQ-010 in_sign  in  1  result sign.
REQ-011 in_exp  in  EXP_W+2  signed biased exponent; gives the weight of in_sum bit WIDTH-1.
REQ-012 in_sticky  in  1  OR of alignment bits discarded upstream.
REQ-013 out_valid  out  1  result beat present.
REQ-014 out_ready  in  1  downstream accepts the result beat.
REQ-015 out_res  out  1+EXP_W+MAN_W  packed IEEE-754 {sign, exp, frac}.
REQ-016 out_flags  out  3  {overflow, underflow, inexact}.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 = leading-zero count plus left shift, S2 = round plus pack. A beat moves between stages on a valid&ready transfer.
REQ-018 Latency: the result SHALL appear as out_valid exactly 2 cycles after input acceptance when out_ready is held at 1. Throughput SHALL be 1 beat per cycle.
REQ-019 Each stage register SHALL load when it is empty or its content leaves in the same cycle. in_ready SHALL be 1 when S1 is empty, or when S1 is full and advances into S2 that same cycle.
REQ-020 While out_valid=1 and out_ready=0, out_res and out_flags SHALL hold stable. No beat SHALL be lost, duplicated or reordered.
REQ-021 S1 rules:
- lz = number of leading zeros of V.
- Normalized word N = V << lz.
- Unrounded exponent e = in_exp + 1 - lz, computed at EXP_W+2 signed bits.
REQ-022 S2 rules:
- mant = N[WIDTH:WIDTH-MAN_W] (MAN_W+1 bits).
- guard = next lower bit.
- sticky = OR of the remaining bits OR in_sticky.
- Rounding is round-to-nearest-even: increment when guard & (sticky | mant LSB).
REQ-023 A rounding carry-out SHALL set mant to the hidden-one pattern and increment e.
REQ-024 Overflow: when final e >= 2^EXP_W-1, the output SHALL be signed infinity with overflow=1 and inexact=1.
REQ-025 Underflow: when final e <= 0 and V != 0, the output SHALL be signed zero with underflow=1 and inexact=1. There is no subnormal output.
REQ-026 Zero: when V == 0, the output SHALL be in_sign zero with flags 0, except inexact = in_sticky.
REQ-027 Inexact SHALL equal guard | sticky in the normal range.
REQ-028 A simultaneous S2 output transfer and S1 advance SHALL occur in the same cycle without a bubble.

Reset
REQ-029 While rst_n=0, both stage valid bits, out_valid and in_ready SHALL be 0. out_res and out_flags SHALL be 0.
REQ-030 in_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-031 Assertion of rst_n mid-operation SHALL discard all in-flight beats immediately. No partial beat SHALL emerge after reset release.

Structure
REQ-032 The following SHALL reside in the shared fp_mac package:
- the packed result typedef {sign, exp, frac};
- the flag typedef;
- the constants BIAS and EXP_MAX.
REQ-033 The leading-zero count SHALL be a single sub-module, fp_lzc #(.width(WIDTH+1)), producing a $clog2(WIDTH+2)-bit count. No other sub-modules SHALL be used.

Verification
REQ-034 V = 1<<73, in_exp = 127, sign 0 -> out_res 0x3F800000, flags 000, out_valid 2 cycles after acceptance.
REQ-035 in_carry=1, in_sum=0, in_exp=127 -> 0x40000000. Separately, in_sum bit73 + bit49 set (tie, even LSB) -> 0x3F800000, inexact=1.
REQ-036 Tie with bit50 also set -> 0x3F800002. in_carry=1, in_exp=254 -> 0x7F800000, overflow=1.
REQ-037 V=0 with in_sign=1 -> 0x80000000, flags 000. bit73 set with in_exp=0 -> 0x00000000, underflow=1.
REQ-038 Backpressure: 4 consecutive beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted. After release, all 4 results emerge in order with stable outputs during the stall.
REQ-039 Reset: rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, no stale beat after release, and in_ready=1 on the next edge.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared fp_mac definitions: packed single-precision result layout, result
// flag layout and the exponent constants used by the MAC datapath and benches.
package fp_mac_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int BIAS     = (1 << (FP_EXP_W - 1)) - 1;
    localparam int EXP_MAX  = (1 << FP_EXP_W) - 1;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] frac;
    } fp_res_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fp_flags_t;

endpackage

// File: rtl/fp_mac_norm_round_if.sv
// Handshake bundle for the normalize/round stage.
//   in_*  : adder-side beat (valid/ready, {carry,sum} magnitude, sign, exp, sticky)
//   out_* : packed IEEE result beat (valid/ready, res, flags)
// master = producer/consumer side (bench or neighbouring stages), slave = the stage.
interface fp_mac_norm_round_if
    import fp_mac_pkg::*;
#(
    parameter int WIDTH = 74,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_sum;
    logic                   in_carry;
    logic                   in_sign;
    logic [EXP_W+1:0]       in_exp;
    logic                   in_sticky;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_res;
    fp_flags_t              out_flags;

    modport master (
        output in_valid, in_sum, in_carry, in_sign, in_exp, in_sticky, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_sign, in_exp, in_sticky, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
endinterface

// File: rtl/fp_mac_norm_round_lzc.sv
// fp_lzc: leading-zero count of a width-bit word.
//   v   : input word
//   cnt : number of zeros above the most significant set bit (width when v==0)
module fp_lzc
    import fp_mac_pkg::*;
#(
    parameter int width = 75
) (
    input  logic [width-1:0]             v,
    output logic [$clog2(width+1)-1:0]   cnt
);
    localparam int CW = $clog2(width + 1);

    // Ascending scan: the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = CW'(width);
        for (int i = 0; i < width; i++)
            if (v[i]) cnt = CW'(width - 1 - i);
    end
endmodule

// File: rtl/fp_mac_norm_round.sv
// fp_mac_norm_round: two-stage normalize + round-to-nearest-even + pack.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fp_mac_norm_round_if
//                S1 = leading-zero count and left shift of V = {in_carry, in_sum}
//                S2 = RNE rounding, overflow/underflow/zero handling, IEEE pack
module fp_mac_norm_round
    import fp_mac_pkg::*;
#(
    parameter int WIDTH = 74,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_mac_norm_round_if.slave   bus
);
    localparam int LZW = $clog2(WIDTH + 2);
    localparam int EW  = EXP_W + 2;
    localparam int RW  = 1 + EXP_W + MAN_W;
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    // ---------------- S1: normalize ----------------
    logic [WIDTH:0]         v, n_nx;
    logic [LZW-1:0]         lz;
    logic signed [EW-1:0]   e_nx;

    assign v    = {bus.in_carry, bus.in_sum};
    assign n_nx = v << lz;
    // in_exp weights bit WIDTH-1; the normalized MSB sits at bit WIDTH, hence +1.
    assign e_nx = bus.in_exp + EW'(1) - EW'(lz);

    fp_lzc #(.width(WIDTH + 1)) u_lzc (.v(v), .cnt(lz));

    logic                   rdy_en;     // holds in_ready low through reset
    logic                   s1_vld, s1_sign, s1_sticky;
    logic [WIDTH:0]         s1_n;
    logic signed [EW-1:0]   s1_e;
    logic                   out_vld;
    logic [RW-1:0]          out_res_q;
    fp_flags_t              out_flg_q;
    logic                   s2_load, s1_load;

    assign s2_load      = !out_vld || bus.out_ready;
    assign s1_load      = rdy_en && (!s1_vld || s2_load);
    assign bus.in_ready = s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_n      <= '0;
            s1_e      <= '0;
            s1_sign   <= 1'b0;
            s1_sticky <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_load) begin
                s1_vld <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_n      <= n_nx;
                    s1_e      <= e_nx;
                    s1_sign   <= bus.in_sign;
                    s1_sticky <= bus.in_sticky;
                end
            end
        end
    end

    // ---------------- S2: round + pack ----------------
    logic [MAN_W-1:0]       frac_in, frac_r;
    logic                   guard, rest, inc, cy;
    logic signed [EW-1:0]   e_f;
    logic [RW-1:0]          res_nx;
    fp_flags_t              flg_nx;

    always_comb begin
        frac_in = s1_n[WIDTH-1 -: MAN_W];
        guard   = s1_n[WIDTH-MAN_W-1];
        rest    = (|s1_n[WIDTH-MAN_W-2:0]) | s1_sticky;
        inc     = guard & (rest | frac_in[0]);
        // Hidden bit is always 1 here, so a carry out of the fraction means
        // 1.11..1 rounded to 10.00..0: fraction wraps to zero, exponent bumps.
        {cy, frac_r} = {1'b0, frac_in} + (MAN_W + 1)'(inc);
        e_f     = s1_e + EW'(cy);
        res_nx  = {s1_sign, e_f[EXP_W-1:0], frac_r};
        flg_nx  = '{ovf: 1'b0, unf: 1'b0, inx: guard | rest};
        if (!s1_n[WIDTH]) begin
            res_nx = {s1_sign, {(RW-1){1'b0}}};
            flg_nx = '{ovf: 1'b0, unf: 1'b0, inx: s1_sticky};
        end else if (e_f >= EMAX) begin
            res_nx = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_nx = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
        end else if (e_f[EW-1] || e_f == '0) begin
            res_nx = {s1_sign, {(RW-1){1'b0}}};
            flg_nx = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_res_q <= '0;
            out_flg_q <= '0;
        end else if (s2_load) begin
            out_vld <= s1_vld;
            if (s1_vld) begin
                out_res_q <= res_nx;
                out_flg_q <= flg_nx;
            end
        end
    end

    assign bus.out_valid = out_vld;
    assign bus.out_res   = out_res_q;
    assign bus.out_flags = out_flg_q;
endmodule

// File: tb/tb_fp_mac_norm_round.sv
// Self-checking bench for fp_mac_norm_round (default parameters).
// Expected results are queued on issue and checked by a monitor on output.
module tb_fp_mac_norm_round;
    import fp_mac_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_mac_norm_round_if bus ();

    fp_mac_norm_round #(.WIDTH(74), .EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;
    int acc  = 0;
    logic [34:0] sb[$];

    // Reference: locate the MSB of V and derive exponent/fraction by weight.
    function automatic logic [34:0] model(input logic [73:0] sum, input logic c, input logic s,
                                          input logic signed [9:0] ex, input logic st);
        logic [74:0] v;
        logic [23:0] m;
        logic [24:0] mr;
        logic        g, r;
        int          p, e;
        v = {c, sum};
        p = -1;
        for (int i = 74; i >= 0; i--)
            if (v[i] && p < 0) p = i;
        if (p < 0) return {s, 31'h0, 2'b00, st};
        v = v << (74 - p);
        m = v[74:51];
        g = v[50];
        r = (|v[49:0]) | st;
        e = int'(ex) + p - 73;
        if (g && (r || m[0])) begin
            mr = {1'b0, m} + 25'd1;
            if (mr[24]) begin
                m = 24'h800000;
                e = e + 1;
            end else begin
                m = mr[23:0];
            end
        end
        if (e >= EXP_MAX) return {s, 8'hFF, 23'h0, 3'b101};
        if (e <= 0)       return {s, 31'h0, 3'b011};
        return {s, 8'(e), m[22:0], 2'b00, g | r};
    endfunction

    // Output monitor: scoreboard compare on transfer, stability check on stall.
    initial begin
        logic        hold_prev;
        logic [34:0] held, got, want;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {bus.out_res, bus.out_flags};
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (bus.out_valid && !bus.out_ready) begin
                    if (hold_prev) begin
                        nvec++;
                        if (got !== held) begin
                            nerr++;
                            $display("FAIL stall_hold got %h want %h", got, held);
                        end
                    end
                    hold_prev = 1'b1;
                    held = got;
                end else begin
                    hold_prev = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    nvec++;
                    if (sb.size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_beat got %h want none", got);
                    end else begin
                        want = sb.pop_front();
                        if (got !== want) begin
                            nerr++;
                            $display("FAIL result got res=%h flags=%b want res=%h flags=%b",
                                     got[34:3], got[2:0], want[34:3], want[2:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [73:0] sum, input logic c, input logic s,
                        input logic signed [9:0] ex, input logic st, input logic [34:0] want);
        int t;
        bus.in_sum    = sum;
        bus.in_carry  = c;
        bus.in_sign   = s;
        bus.in_exp    = ex;
        bus.in_sticky = st;
        bus.in_valid  = 1'b1;
        sb.push_back(want);
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        acc++;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [73:0]        sum;
        logic               c, s, st;
        logic signed [9:0]  ex;
        sum = 74'({$urandom(), $urandom(), $urandom()});
        sum = sum >> $urandom_range(0, 80);
        c   = ($urandom_range(0, 7) == 0);
        s   = 1'($urandom());
        st  = 1'($urandom());
        ex  = 10'(int'($urandom_range(0, 300)) - 20);
        send(sum, c, s, ex, st, model(sum, c, s, ex, st));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        nvec++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00 || bus.out_res !== 32'h0 || bus.out_flags !== 3'b000) begin
            nerr++;
            $display("FAIL reset_state got v=%b r=%b res=%h fl=%b want 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_res, bus.out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL ready_after_reset got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        logic [73:0] b;
        b = 74'(1) << 73;
        bus.out_ready = 1'b1;
        bus.in_sum = b; bus.in_carry = 1'b0; bus.in_sign = 1'b0;
        bus.in_exp = 10'(BIAS); bus.in_sticky = 1'b0; bus.in_valid = 1'b1;
        sb.push_back({32'h3F800000, 3'b000});
        @(negedge clk);
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL latency_accept got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL latency_cycle1 got %b want 0", bus.out_valid);
        end
        @(negedge clk);
        nvec++;
        if (bus.out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL latency_cycle2 got %b want 1", bus.out_valid);
        end
        drain();
    endtask

    task automatic test_directed();
        logic [73:0] b73, b49, b50, z;
        z   = '0;
        b73 = 74'(1) << 73;
        b49 = 74'(1) << 49;
        b50 = 74'(1) << 50;
        bus.out_ready = 1'b1;
        send(z,               1'b1, 1'b0, 10'd127, 1'b0, {32'h40000000, 3'b000});
        send(b73 | b49,       1'b0, 1'b0, 10'd127, 1'b0, {32'h3F800000, 3'b001});
        send(b73 | b50 | b49, 1'b0, 1'b0, 10'd127, 1'b0, {32'h3F800002, 3'b001});
        send(z,               1'b1, 1'b0, 10'd254, 1'b0, {32'h7F800000, 3'b101});
        send(z,               1'b0, 1'b1, 10'd127, 1'b0, {32'h80000000, 3'b000});
        send(b73,             1'b0, 1'b0, 10'd0,   1'b0, {32'h00000000, 3'b011});
        send(z,               1'b0, 1'b0, 10'd127, 1'b1, {32'h00000000, 3'b001});
        send(z,               1'b1, 1'b1, 10'd253, 1'b1, {32'hFF000000, 3'b001});
        drain();
    endtask

    task automatic test_back_to_back();
        time t0;
        bus.out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) send_rand();
        nvec++;
        if (($time - t0) / 10 != 8) begin
            nerr++;
            $display("FAIL throughput got %0d cycles want 8", ($time - t0) / 10);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        acc = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                nvec++;
                if (bus.in_ready !== 1'b0 || acc != 2 || bus.out_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL backpressure got ready=%b acc=%0d ov=%b want 0 2 1",
                             bus.in_ready, acc, bus.out_valid);
                end
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_random();
        logic done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_midflight();
        logic bad;
        bus.out_ready = 1'b1;
        send_rand();
        send_rand();
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL midflight_reset got ov=%b r=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midflight_ready got %b want 1", bus.in_ready);
        end
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad = 1'b1;
        end
        nvec++;
        if (bad) begin
            nerr++;
            $display("FAIL stale_beat got out_valid=1 want 0");
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
